// File: rtl/jtag_tap_responder.sv
// JTAG TAP target sampled on clk: 16-state TAP FSM with IR, BYPASS, IDCODE and one user DR.
// Define JTAG_TAP_TRST_EN to add the asynchronous trst_n pin.
module jtag_tap_responder #(
    parameter int                  IR_WIDTH      = 4,
    parameter int                  DR_WIDTH      = 32,
    parameter logic [31:0]         IDCODE_VALUE  = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0] IDCODE_OPCODE = IR_WIDTH'(4'h1),
    parameter logic [IR_WIDTH-1:0] USER_OPCODE   = IR_WIDTH'(4'h8),
    parameter int                  SYNC_STAGES   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tck,
    input  logic                tms,
    input  logic                tdi,
`ifdef JTAG_TAP_TRST_EN
    input  logic                trst_n,
`endif
    output logic                tdo,
    output logic                tdo_oe,
    input  logic [DR_WIDTH-1:0] user_capture_data,
    output logic [DR_WIDTH-1:0] user_update_data,
    output logic                user_update,
    output logic [3:0]          tap_state,
    output logic                tlr
);
    typedef enum logic [3:0] {
        EX2_DR = 4'h0, EX1_DR = 4'h1, SH_DR  = 4'h2, PAU_DR = 4'h3,
        SEL_IR = 4'h4, UPD_DR = 4'h5, CAP_DR = 4'h6, SEL_DR = 4'h7,
        EX2_IR = 4'h8, EX1_IR = 4'h9, SH_IR  = 4'hA, PAU_IR = 4'hB,
        RTI    = 4'hC, UPD_IR = 4'hD, CAP_IR = 4'hE, TLR    = 4'hF
    } tap_state_e;

    localparam int GUARD_W = $clog2(SYNC_STAGES + 2);

    logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync;
    logic                   tck_s, tms_s, tdi_s, tck_d;
    logic [GUARD_W-1:0]     guard_cnt;
    logic                   trst_active, edge_ok, rise, fall, rise_p1;
    tap_state_e             state_q, state_nxt;
    logic [IR_WIDTH-1:0]    ir, ir_shift;
    logic                   bypass_reg;
    logic [31:0]            idcode_shift;
    logic [DR_WIDTH-1:0]    user_shift;
    logic                   sel_idcode, sel_user, dr_lsb, upd_dr_go;

    // Stage p0: synchronizers; tck, tms and tdi share the same depth so they stay aligned
    always_ff @(posedge clk) begin
        tck_sync[0] <= tck;
        tms_sync[0] <= tms;
        tdi_sync[0] <= tdi;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            tck_sync[i] <= tck_sync[i-1];
            tms_sync[i] <= tms_sync[i-1];
            tdi_sync[i] <= tdi_sync[i-1];
        end
        tck_d <= tck_s;
    end

    assign tck_s = tck_sync[SYNC_STAGES-1];
    assign tms_s = tms_sync[SYNC_STAGES-1];
    assign tdi_s = tdi_sync[SYNC_STAGES-1];

`ifdef JTAG_TAP_TRST_EN
    logic [SYNC_STAGES-1:0] trst_sync;
    always_ff @(posedge clk) begin
        trst_sync[0] <= trst_n;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            trst_sync[i] <= trst_sync[i-1];
        end
    end
    assign trst_active = ~trst_sync[SYNC_STAGES-1];
`else
    assign trst_active = 1'b0;
`endif

    // The guard covers the time the synchronizer chain needs to refill after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            guard_cnt <= GUARD_W'(SYNC_STAGES + 1);
        end else if (guard_cnt != '0) begin
            guard_cnt <= guard_cnt - GUARD_W'(1);
        end
    end

    assign edge_ok = (guard_cnt == '0) && !rst && !trst_active;
    assign rise    = edge_ok && tck_s && !tck_d;
    assign fall    = edge_ok && !tck_s && tck_d;

    // Stage p1: TAP state register and next-state decode
    always_ff @(posedge clk) begin
        if (rst || trst_active) begin
            state_q <= TLR;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (rise) begin
            case (state_q)
                TLR:     state_nxt = tms_s ? TLR    : RTI;
                RTI:     state_nxt = tms_s ? SEL_DR : RTI;
                SEL_DR:  state_nxt = tms_s ? SEL_IR : CAP_DR;
                CAP_DR:  state_nxt = tms_s ? EX1_DR : SH_DR;
                SH_DR:   state_nxt = tms_s ? EX1_DR : SH_DR;
                EX1_DR:  state_nxt = tms_s ? UPD_DR : PAU_DR;
                PAU_DR:  state_nxt = tms_s ? EX2_DR : PAU_DR;
                EX2_DR:  state_nxt = tms_s ? UPD_DR : SH_DR;
                UPD_DR:  state_nxt = tms_s ? SEL_DR : RTI;
                SEL_IR:  state_nxt = tms_s ? TLR    : CAP_IR;
                CAP_IR:  state_nxt = tms_s ? EX1_IR : SH_IR;
                SH_IR:   state_nxt = tms_s ? EX1_IR : SH_IR;
                EX1_IR:  state_nxt = tms_s ? UPD_IR : PAU_IR;
                PAU_IR:  state_nxt = tms_s ? EX2_IR : PAU_IR;
                EX2_IR:  state_nxt = tms_s ? UPD_IR : SH_IR;
                UPD_IR:  state_nxt = tms_s ? SEL_DR : RTI;
                default: state_nxt = TLR;
            endcase
        end
    end

    assign sel_idcode = (ir == IDCODE_OPCODE);
    assign sel_user   = !sel_idcode && (ir == USER_OPCODE);

    always_comb begin
        dr_lsb = bypass_reg;
        if (sel_idcode) begin
            dr_lsb = idcode_shift[0];
        end else if (sel_user) begin
            dr_lsb = user_shift[0];
        end
    end

    // Shift registers act on rise using the state before the transition
    always_ff @(posedge clk) begin
        if (rise) begin
            case (state_q)
                CAP_IR: ir_shift <= IR_WIDTH'(1);
                SH_IR:  ir_shift <= {tdi_s, ir_shift[IR_WIDTH-1:1]};
                CAP_DR: begin
                    if (sel_idcode) begin
                        idcode_shift <= IDCODE_VALUE;
                    end else if (sel_user) begin
                        user_shift <= user_capture_data;
                    end else begin
                        bypass_reg <= 1'b0;
                    end
                end
                SH_DR: begin
                    if (sel_idcode) begin
                        idcode_shift <= {tdi_s, idcode_shift[31:1]};
                    end else if (sel_user) begin
                        user_shift <= {tdi_s, user_shift[DR_WIDTH-1:1]};
                    end else begin
                        bypass_reg <= tdi_s;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p2: update actions one clk after reaching an Update state; tdo driven on fall
    assign upd_dr_go = rise_p1 && (state_q == UPD_DR) && sel_user && !trst_active;

    always_ff @(posedge clk) begin
        if (rst || trst_active) begin
            ir          <= IDCODE_OPCODE;
            tdo         <= 1'b0;
            tdo_oe      <= 1'b0;
            user_update <= 1'b0;
            rise_p1     <= 1'b0;
        end else begin
            rise_p1     <= rise;
            user_update <= upd_dr_go;
            if (state_q == TLR) begin
                ir <= IDCODE_OPCODE;
            end else if (rise_p1 && state_q == UPD_IR) begin
                ir <= ir_shift;
            end
            if (fall) begin
                if (state_q == SH_IR) begin
                    tdo    <= ir_shift[0];
                    tdo_oe <= 1'b1;
                end else if (state_q == SH_DR) begin
                    tdo    <= dr_lsb;
                    tdo_oe <= 1'b1;
                end else begin
                    tdo    <= 1'b0;
                    tdo_oe <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            user_update_data <= '0;
        end else if (upd_dr_go) begin
            user_update_data <= user_shift;
        end
    end

    assign tap_state = state_q;
    assign tlr       = (state_q == TLR);
endmodule

// File: tb/tb_jtag_tap_responder.sv
// Self-checking bench for jtag_tap_responder: table-driven TAP model, directed scans and random walks.
`timescale 1ns/1ps
module tb_jtag_tap_responder;
    localparam int HALF = 6;  // clk periods per tck phase

    logic        clk = 1'b0;
    logic        rst, tck, tms, tdi, trst_n;
    logic        tdo, tdo_oe, user_update, tlr;
    logic [31:0] cap_data, user_update_data;
    logic [3:0]  tap_state;

    int total = 0;
    int bad   = 0;
    int pulse_cnt = 0;

    // Reference model state
    logic [3:0]  m_state, m_ir, m_irs;
    logic        m_byp;
    logic [31:0] m_idc, m_usr, m_upd;
    int          m_pulses;

    // IEEE 1149.1 next-state tables indexed by state code: [tms=0], [tms=1]
    logic [3:0] nxt0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                              4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    logic [3:0] nxt1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                              4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

    always #5 clk = ~clk;

    jtag_tap_responder dut (
        .clk               (clk),
        .rst               (rst),
        .tck               (tck),
        .tms               (tms),
        .tdi               (tdi),
`ifdef JTAG_TAP_TRST_EN
        .trst_n            (trst_n),
`endif
        .tdo               (tdo),
        .tdo_oe            (tdo_oe),
        .user_capture_data (cap_data),
        .user_update_data  (user_update_data),
        .user_update       (user_update),
        .tap_state         (tap_state),
        .tlr               (tlr)
    );

    always @(negedge clk) if (user_update === 1'b1) pulse_cnt <= pulse_cnt + 1;

    function automatic int dr_sel(input logic [3:0] ir_v);
        if (ir_v == 4'h1) return 1;
        if (ir_v == 4'h8) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_state = 4'hF;
        m_ir    = 4'h1;
        m_upd   = 32'h0;
    endtask

    // One full tck period; the model advances, then the DUT is checked after rise and after fall
    task automatic tck_cycle(input logic t, input logic d, output logic o);
        logic exp_tdo, exp_oe;
        int   s;
        s = dr_sel(m_ir);
        case (m_state)
            4'hE: m_irs = 4'h1;
            4'hA: m_irs = (m_irs >> 1) | (4'(d) << 3);
            4'h6: begin
                if (s == 1) m_idc = 32'h1000_0001;
                else if (s == 2) m_usr = cap_data;
                else m_byp = 1'b0;
            end
            4'h2: begin
                if (s == 1) m_idc = (m_idc >> 1) | (32'(d) << 31);
                else if (s == 2) m_usr = (m_usr >> 1) | (32'(d) << 31);
                else m_byp = d;
            end
            default: ;
        endcase
        m_state = t ? nxt1[m_state] : nxt0[m_state];
        if (m_state == 4'hD) m_ir = m_irs;
        if (m_state == 4'h5 && s == 2) begin
            m_upd = m_usr;
            m_pulses++;
        end
        if (m_state == 4'hF) m_ir = 4'h1;

        tms = t;
        tdi = d;
        tck = 1'b1;
        repeat (HALF) @(negedge clk);
        total++;
        if (tap_state !== m_state) begin
            bad++;
            $display("FAIL tap_state actual=%h required=%h", tap_state, m_state);
        end
        total++;
        if (tlr !== (m_state == 4'hF)) begin
            bad++;
            $display("FAIL tlr actual=%b required=%b", tlr, m_state == 4'hF);
        end
        tck = 1'b0;
        repeat (HALF) @(negedge clk);

        exp_oe  = 1'b0;
        exp_tdo = 1'b0;
        if (m_state == 4'hA) begin
            exp_oe  = 1'b1;
            exp_tdo = m_irs[0];
        end else if (m_state == 4'h2) begin
            exp_oe  = 1'b1;
            s = dr_sel(m_ir);
            exp_tdo = (s == 1) ? m_idc[0] : (s == 2) ? m_usr[0] : m_byp;
        end
        total++;
        if (tdo !== exp_tdo || tdo_oe !== exp_oe) begin
            bad++;
            $display("FAIL tdo/oe actual=%b/%b required=%b/%b state=%h", tdo, tdo_oe, exp_tdo, exp_oe, m_state);
        end
        total++;
        if (user_update_data !== m_upd || pulse_cnt != m_pulses) begin
            bad++;
            $display("FAIL update actual=%h/%0d required=%h/%0d", user_update_data, pulse_cnt, m_upd, m_pulses);
        end
        o = tdo;
    endtask

    // From RTI: scan n bits through IR or DR, return to RTI; dout holds tdo LSB-first
    task automatic scan(input logic is_ir, input int n, input logic [63:0] din, output logic [63:0] dout);
        logic o;
        dout = '0;
        tck_cycle(1'b1, 1'b0, o);
        if (is_ir) tck_cycle(1'b1, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
        dout[0] = o;
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, din[i], o);
            if (i < n - 1) dout[i+1] = o;
        end
        tck_cycle(1'b1, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
    endtask

    task automatic apply_rst();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        // a rise while reset is held must be lost
        tms = 1'b0;
        tck = 1'b1;
        repeat (HALF) @(negedge clk);
        tck = 1'b0;
        repeat (HALF) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        total++;
        if (tap_state !== 4'hF || tlr !== 1'b1) begin
            bad++;
            $display("FAIL reset_state actual=%h/%b required=f/1", tap_state, tlr);
        end
        total++;
        if (tdo !== 1'b0 || tdo_oe !== 1'b0 || user_update !== 1'b0 || user_update_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs actual=%b/%b/%b/%h required=0/0/0/0", tdo, tdo_oe, user_update, user_update_data);
        end
    endtask

    task automatic test_idcode();
        logic        o;
        logic [63:0] dout;
        tck_cycle(1'b0, 1'b0, o);
        scan(1'b0, 32, 64'h0, dout);
        total++;
        if (dout[31:0] !== 32'h1000_0001) begin
            bad++;
            $display("FAIL idcode actual=%h required=10000001", dout[31:0]);
        end
    endtask

    task automatic test_user();
        logic [63:0] dout;
        int          p0;
        scan(1'b1, 4, 64'h8, dout);
        total++;
        if (dout[3:0] !== 4'b0001) begin
            bad++;
            $display("FAIL ir_capture actual=%b required=0001", dout[3:0]);
        end
        cap_data = 32'hDEADBEEF;
        p0 = pulse_cnt;
        scan(1'b0, 32, 64'h1234_5678, dout);
        total++;
        if (dout[31:0] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL user_capture actual=%h required=deadbeef", dout[31:0]);
        end
        total++;
        if (user_update_data !== 32'h1234_5678 || pulse_cnt - p0 != 1) begin
            bad++;
            $display("FAIL user_update actual=%h pulses=%0d required=12345678 pulses=1", user_update_data, pulse_cnt - p0);
        end
    endtask

    task automatic test_bypass();
        logic [63:0] dout;
        scan(1'b1, 4, 64'h3, dout);
        scan(1'b0, 8, 64'hA5, dout);
        total++;
        if (dout[7:0] !== 8'h4A) begin
            bad++;
            $display("FAIL bypass actual=%h required=4a", dout[7:0]);
        end
    endtask

    task automatic test_tlr_from_shdr();
        logic        o;
        logic [63:0] dout;
        int          p0;
        p0 = pulse_cnt;
        tck_cycle(1'b1, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
        repeat (5) tck_cycle(1'b1, 1'b0, o);
        total++;
        if (tap_state !== 4'hF || pulse_cnt != p0) begin
            bad++;
            $display("FAIL five_tms actual=%h pulses=%0d required=f pulses=0", tap_state, pulse_cnt - p0);
        end
        tck_cycle(1'b0, 1'b0, o);
        scan(1'b0, 32, 64'h0, dout);
        total++;
        if (dout[31:0] !== 32'h1000_0001) begin
            bad++;
            $display("FAIL ir_after_tlr actual=%h required=10000001", dout[31:0]);
        end
    endtask

    task automatic test_rst_mid_shift();
        logic        o;
        logic [63:0] dout;
        scan(1'b1, 4, 64'h8, dout);
        tck_cycle(1'b1, 1'b0, o);
        tck_cycle(1'b1, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
        tck_cycle(1'b0, 1'b1, o);
        tck_cycle(1'b0, 1'b1, o);
        apply_rst();
        total++;
        if (tap_state !== 4'hF || tdo_oe !== 1'b0 || tlr !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_shift actual=%h/%b/%b required=f/0/1", tap_state, tdo_oe, tlr);
        end
        tck_cycle(1'b0, 1'b0, o);
        scan(1'b0, 32, 64'h0, dout);
        total++;
        if (dout[31:0] !== 32'h1000_0001) begin
            bad++;
            $display("FAIL ir_after_rst actual=%h required=10000001", dout[31:0]);
        end
    endtask

`ifdef JTAG_TAP_TRST_EN
    task automatic test_trst();
        logic        o;
        logic [63:0] dout;
        scan(1'b1, 4, 64'h8, dout);
        scan(1'b0, 32, 64'hCAFE_F00D, dout);
        tck_cycle(1'b1, 1'b0, o);
        tck_cycle(1'b1, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
        tck_cycle(1'b0, 1'b1, o);
        tck_cycle(1'b0, 1'b1, o);
        trst_n = 1'b0;
        repeat (4) @(negedge clk);
        tms = 1'b0;
        tck = 1'b1;
        repeat (HALF) @(negedge clk);
        tck = 1'b0;
        repeat (HALF) @(negedge clk);
        total++;
        if (tap_state !== 4'hF || tdo_oe !== 1'b0 || user_update_data !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL trst actual=%h/%b/%h required=f/0/cafef00d", tap_state, tdo_oe, user_update_data);
        end
        trst_n = 1'b1;
        m_state = 4'hF;
        m_ir    = 4'h1;
        repeat (5) @(negedge clk);
        tck_cycle(1'b0, 1'b0, o);
        scan(1'b0, 32, 64'h0, dout);
        total++;
        if (dout[31:0] !== 32'h1000_0001) begin
            bad++;
            $display("FAIL ir_after_trst actual=%h required=10000001", dout[31:0]);
        end
    endtask
`endif

    task automatic test_random();
        logic        o;
        logic [63:0] dout, din;
        logic [3:0]  op;
        int          n;
        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 3))
                0: op = 4'h1;
                1: op = 4'h8;
                2: op = 4'h3;
                default: op = 4'($urandom);
            endcase
            scan(1'b1, 4, 64'(op), dout);
            cap_data = $urandom;
            n = $urandom_range(1, 40);
            din = {$urandom, $urandom};
            scan(1'b0, n, din, dout);
        end
        for (int k = 0; k < 120; k++) begin
            cap_data = $urandom;
            tck_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
        end
        repeat (5) tck_cycle(1'b1, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
    endtask

    initial begin
        rst = 1'b1; tck = 1'b0; tms = 1'b1; tdi = 1'b0; trst_n = 1'b1;
        cap_data = 32'h0;
        m_irs = 4'h0; m_byp = 1'b0; m_idc = 32'h0; m_usr = 32'h0; m_pulses = 0;
        model_reset();
        test_reset();
        test_idcode();
        test_user();
        test_bypass();
        test_tlr_from_shdr();
        test_rst_mid_shift();
`ifdef JTAG_TAP_TRST_EN
        test_trst();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
